// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, sequencer state encoding and opcode legality check shared by alu_seq
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_NOP = 3'b111;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHL};
    endfunction

endpackage

// File: rtl/alu_seq.sv
// alu_seq: command sequencer driving an external 32-bit ALU; optional perf counters under ALU_SEQ_PERF_EN
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic [DATA_W-1:0]  cmd_a,
    input  logic [DATA_W-1:0]  cmd_b,
    input  logic [SHAMT_W-1:0] cmd_shamt,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_y,
    output logic               rsp_cout,
    output logic               rsp_zero,
    output logic               rsp_err,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [2:0]         alu_op,
    input  logic [DATA_W-1:0]  alu_y,
    input  logic               alu_cout,
    input  logic               alu_zero
`ifdef ALU_SEQ_PERF_EN
    ,
    output logic [31:0]        perf_cmds,
    output logic [31:0]        perf_busy
`endif
);

    state_t             state;
    logic [2:0]         op_r;
    logic [DATA_W-1:0]  b_r;
    logic [DATA_W-1:0]  work;
    logic [SHAMT_W-1:0] count;

    assign cmd_ready = state == IDLE;
    assign rsp_valid = state == RESP;

    // ALU lines are live only in EXEC; elsewhere the ALU sees a NOP with zero operands
    always_comb begin
        alu_op = state == EXEC ? op_r : OP_NOP;
        alu_a  = state == EXEC ? work : '0;
        alu_b  = state == EXEC ? b_r : '0;
    end

    // IDLE -> EXEC -> RESP -> IDLE, with illegal-op and zero-shift shortcuts straight to RESP
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            op_r     <= OP_NOP;
            b_r      <= '0;
            work     <= '0;
            count    <= '0;
            rsp_y    <= '0;
            rsp_cout <= 1'b0;
            rsp_zero <= 1'b0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    op_r  <= cmd_op;
                    b_r   <= cmd_op == OP_SHL ? '0 : cmd_b;
                    work  <= cmd_a;
                    count <= cmd_shamt;
                    if (!is_legal_op(cmd_op)) begin
                        state    <= RESP;
                        rsp_y    <= '0;
                        rsp_cout <= 1'b0;
                        rsp_zero <= 1'b1;
                        rsp_err  <= 1'b1;
                    end else if (cmd_op == OP_SHL && cmd_shamt == '0) begin
                        state    <= RESP;
                        rsp_y    <= cmd_a;
                        rsp_cout <= 1'b0;
                        rsp_zero <= cmd_a == '0;
                        rsp_err  <= 1'b0;
                    end else begin
                        state   <= EXEC;
                        rsp_err <= 1'b0;
                    end
                end
                EXEC: begin
                    rsp_y    <= alu_y;
                    rsp_cout <= alu_cout;
                    rsp_zero <= alu_zero;
                    count    <= count - SHAMT_W'(1);
                    if (op_r == OP_SHL) work <= alu_y;
                    if (op_r != OP_SHL || count == SHAMT_W'(1)) state <= RESP;
                end
                RESP: if (rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_SEQ_PERF_EN
    // free-running counters of consumed responses and non-idle cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_cmds <= '0;
            perf_busy <= '0;
        end else begin
            if (rsp_valid && rsp_ready) perf_cmds <= perf_cmds + 32'd1;
            if (state != IDLE) perf_busy <= perf_busy + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized and directed bench for alu_seq against a transaction-level reference model
module tb_alu_seq;

    typedef struct packed {
        logic [31:0] y;
        logic        c;
        logic        z;
        logic        e;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [31:0] cmd_a = 32'd0;
    logic [31:0] cmd_b = 32'd0;
    logic [4:0]  cmd_shamt = 5'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_y;
    logic        rsp_cout;
    logic        rsp_zero;
    logic        rsp_err;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_y;
    logic        alu_cout;
    logic        alu_zero;
`ifdef ALU_SEQ_PERF_EN
    logic [31:0] perf_cmds;
    logic [31:0] perf_busy;
`endif

    int n_vec = 0;
    int n_bad = 0;
    int n_done = 0;

    alu_seq dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_shamt(cmd_shamt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
        .rsp_cout(rsp_cout), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_y(alu_y), .alu_cout(alu_cout), .alu_zero(alu_zero)
`ifdef ALU_SEQ_PERF_EN
        , .perf_cmds(perf_cmds), .perf_busy(perf_busy)
`endif
    );

    always #5 clk = ~clk;

    // the external combinational ALU the sequencer is meant to drive
    always_comb begin
        logic [32:0] s;
        s = 33'd0;
        case (alu_op)
            3'd0: s = {1'b0, alu_a} + {1'b0, alu_b};
            3'd1: s = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
            3'd2: s = {1'b0, alu_a & alu_b};
            3'd3: s = {1'b0, alu_a | alu_b};
            3'd4: s = {alu_a, 1'b0};
            default: s = 33'd0;
        endcase
        alu_y    = s[31:0];
        alu_cout = s[32];
        alu_zero = s[31:0] == 32'd0;
    end

    function automatic rsp_t ref_rsp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                     input logic [4:0] sh);
        rsp_t r;
        logic [32:0] s;
        logic [63:0] w;
        r = '0;
        case (op)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; r.y = s[31:0]; r.c = s[32]; end
            3'd1: begin r.y = a - b; r.c = a >= b; end
            3'd2: r.y = a & b;
            3'd3: r.y = a | b;
            3'd4: begin w = {32'd0, a} << sh; r.y = w[31:0]; r.c = sh != 5'd0 && w[32]; end
            default: r.e = 1'b1;
        endcase
        r.z = r.y == 32'd0;
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [4:0] sh);
        return op > 3'd4 ? 1 : op == 3'd4 ? (sh == 5'd0 ? 1 : int'(sh) + 1) : 2;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // transaction-level model: idle, busy for a computed number of ALU cycles, then holding a response
    logic        m_busy = 1'b0;
    logic        m_valid = 1'b0;
    int          m_left = 0;
    int          m_step = 0;
    logic [2:0]  m_op = 3'd7;
    logic [31:0] m_a = 32'd0;
    logic [31:0] m_b = 32'd0;
    rsp_t        m_pend = '0;
    rsp_t        m_rsp = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_rsp   <= '0;
            m_step  <= 0;
        end else if (!m_busy && !m_valid) begin
            if (cmd_valid) begin
                m_op   <= cmd_op;
                m_a    <= cmd_a;
                m_b    <= cmd_b;
                m_step <= 0;
                m_pend <= ref_rsp(cmd_op, cmd_a, cmd_b, cmd_shamt);
                if (ref_lat(cmd_op, cmd_shamt) == 1) begin
                    m_valid <= 1'b1;
                    m_rsp   <= ref_rsp(cmd_op, cmd_a, cmd_b, cmd_shamt);
                end else begin
                    m_busy <= 1'b1;
                    m_left <= ref_lat(cmd_op, cmd_shamt) - 1;
                end
            end
        end else if (m_busy) begin
            m_step <= m_step + 1;
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy  <= 1'b0;
                m_valid <= 1'b1;
                m_rsp   <= m_pend;
            end
        end else if (rsp_ready) begin
            m_valid <= 1'b0;
        end
    end

    // every-cycle comparison of the DUT against the model, away from the active edge
    always @(negedge clk) begin
        chk("cmd_ready", 32'(cmd_ready), 32'(!m_busy && !m_valid));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        chk("alu_op", 32'(alu_op), m_busy ? 32'(m_op) : 32'd7);
        chk("alu_a", alu_a, m_busy ? (m_op == 3'd4 ? m_a << m_step : m_a) : 32'd0);
        chk("alu_b", alu_b, m_busy && m_op != 3'd4 ? m_b : 32'd0);
        if (!m_busy) begin
            chk("rsp_y", rsp_y, m_rsp.y);
            chk("rsp_cout", 32'(rsp_cout), 32'(m_rsp.c));
            chk("rsp_zero", 32'(rsp_zero), 32'(m_rsp.z));
            chk("rsp_err", 32'(rsp_err), 32'(m_rsp.e));
        end
    end

    task automatic scramble();
        cmd_valid = 1'($urandom);
        cmd_op    = 3'($urandom);
        cmd_a     = $urandom;
        cmd_b     = $urandom;
        cmd_shamt = 5'($urandom);
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sh, input int hold,
                           output rsp_t got, output int lat, output int n_exec);
        int w;
        @(negedge clk);
        w = 0;
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("accept_wait", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_shamt = sh;
        lat = 0;
        n_exec = 0;
        do begin
            @(negedge clk);
            lat++;
            if (alu_op == 3'd4) n_exec++;
            scramble();
        end while (!rsp_valid && lat < 100);
        chk("rsp_timeout", 32'(rsp_valid), 32'd1);
        got = {rsp_y, rsp_cout, rsp_zero, rsp_err};
        repeat (hold) begin
            @(negedge clk);
            scramble();
        end
        rsp_ready = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_done++;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        rsp_t got;
        int lat;
        int nx;
        logic [2:0] op;
        logic [4:0] sh;
        logic [31:0] a;
        logic [31:0] b;

        chk("model_add", ref_rsp(3'd0, 32'hFFFFFFFF, 32'd1, 5'd0), {32'h0, 1'b1, 1'b1, 1'b0});
        chk("model_sub57", ref_rsp(3'd1, 32'd5, 32'd7, 5'd0), {32'hFFFFFFFE, 1'b0, 1'b0, 1'b0});
        chk("model_sub75", ref_rsp(3'd1, 32'd7, 32'd5, 5'd0), {32'h2, 1'b1, 1'b0, 1'b0});
        chk("model_shl4", ref_rsp(3'd4, 32'd3, 32'd9, 5'd4), {32'h30, 1'b0, 1'b0, 1'b0});
        chk("model_shl_msb", ref_rsp(3'd4, 32'h80000000, 32'd0, 5'd1), {32'h0, 1'b1, 1'b1, 1'b0});
        chk("model_illegal", ref_rsp(3'd6, 32'd5, 32'd5, 5'd3), {32'h0, 1'b0, 1'b1, 1'b1});
        chk("model_lat_shl4", ref_lat(3'd4, 5'd4), 32'd5);

        repeat (3) @(negedge clk);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_y", rsp_y, 32'd0);
        chk("reset_alu_op", 32'(alu_op), 32'd7);
        reset = 1'b0;

        run_cmd(3'd0, 32'hFFFFFFFF, 32'd1, 5'd0, 0, got, lat, nx);
        chk("add_lat", lat, 32'd2);
        chk("add_rsp", got, {32'h0, 1'b1, 1'b1, 1'b0});
        run_cmd(3'd1, 32'd5, 32'd7, 5'd0, 1, got, lat, nx);
        chk("sub57_rsp", got, {32'hFFFFFFFE, 1'b0, 1'b0, 1'b0});
        run_cmd(3'd1, 32'd7, 32'd5, 5'd0, 0, got, lat, nx);
        chk("sub75_rsp", got, {32'h2, 1'b1, 1'b0, 1'b0});
        run_cmd(3'd4, 32'd3, 32'd0, 5'd4, 0, got, lat, nx);
        chk("shl4_lat", lat, 32'd5);
        chk("shl4_exec", nx, 32'd4);
        chk("shl4_y", got.y, 32'h30);
        run_cmd(3'd4, 32'h80000000, 32'd0, 5'd1, 0, got, lat, nx);
        chk("shl_msb_rsp", got, {32'h0, 1'b1, 1'b1, 1'b0});
        run_cmd(3'd6, 32'h55, 32'h66, 5'd2, 0, got, lat, nx);
        chk("illegal_lat", lat, 32'd1);
        chk("illegal_rsp", got, {32'h0, 1'b0, 1'b1, 1'b1});
        run_cmd(3'd4, 32'h1234, 32'h9, 5'd0, 0, got, lat, nx);
        chk("shl0_lat", lat, 32'd1);
        chk("shl0_exec", nx, 32'd0);
        chk("shl0_rsp", got, {32'h1234, 1'b0, 1'b0, 1'b0});
        run_cmd(3'd2, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 10, got, lat, nx);
        chk("and_rsp", got.y, 32'hF000F000);
        chk("and_release_ready", 32'(cmd_ready), 32'd1);

        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 3'd4;
        cmd_a     = $urandom | 32'h1;
        cmd_shamt = 5'd20;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_in_exec", 32'(alu_op), 32'd4);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (30) @(negedge clk);
        run_cmd(3'd3, 32'h1, 32'h2, 5'd0, 0, got, lat, nx);
        chk("or_after_abort", got.y, 32'h3);

        for (int i = 0; i < 80; i++) begin
            op = 3'($urandom);
            sh = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            a  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            b  = ($urandom_range(0, 7) == 0) ? ~a : ($urandom_range(0, 7) == 0 ? a : $urandom);
            run_cmd(op, a, b, sh, $urandom_range(0, 3), got, lat, nx);
            chk("rand_lat", lat, ref_lat(op, sh));
            chk("rand_rsp", got, ref_rsp(op, a, b, sh));
        end

`ifdef ALU_SEQ_PERF_EN
        chk("perf_cmds", perf_cmds, n_done);
`endif
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Command sequencer that drives the team's 32-bit combinational ALU (ops ADD/SUB/AND/OR/SHL-by-1, flags Cout/Zero) from the initiator side.
- Accepts one command at a time over a valid/ready request channel and drives the ALU operand and opcode lines.
- Iterates the ALU's 1-bit shift to implement SHL by N, captures the result and flags, and returns them over a valid/ready response channel.
- Sits between a host/control FSM and the ALU instance; the parent connects the alu_* ports to the ALU.

Parameters:
DATA_W, 32, operand/result width; must equal the ALU width.
SHAMT_W, 5, shift-amount width; maximum shift is 2^SHAMT_W-1.

Ports:
clk  in  1  system clock, single clock domain
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 SHL-by-N, 101..111 illegal
cmd_a  in  DATA_W  operand A
cmd_b  in  DATA_W  operand B; ignored for SHL
cmd_shamt  in  SHAMT_W  shift amount; SHL only
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_y  out  DATA_W  result
rsp_cout  out  1  carry out
rsp_zero  out  1  result-is-zero flag
rsp_err  out  1  illegal opcode
alu_a  out  DATA_W  to ALU operand A
alu_b  out  DATA_W  to ALU operand B
alu_op  out  3  to ALU opcode
alu_y  in  DATA_W  from ALU result
alu_cout  in  1  from ALU carry out
alu_zero  in  1  from ALU zero flag

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: state IDLE; cmd_ready=1; rsp_valid=0; rsp_y=0; rsp_cout=0; rsp_zero=0; rsp_err=0; count=0.
- Command acceptance:
  - cmd_ready=1 only in IDLE.
  - Handshake occurs when cmd_valid&cmd_ready at a rising edge; op, a, b and shamt are latched into internal registers.
- FSM: IDLE -> EXEC -> RESP -> IDLE. Shortcuts from IDLE straight to RESP:
  - Illegal op: rsp_err=1, rsp_y=0, rsp_cout=0, rsp_zero=1; no ALU cycle.
  - SHL with shamt=0: rsp_y=a, rsp_cout=0, rsp_zero=(a==0), rsp_err=0; no ALU cycle.
  - Both shortcuts give rsp_valid one cycle after acceptance.
- EXEC state:
  - ALU drive: alu_op = latched op; alu_a = working register; alu_b = latched b (0 for SHL).
  - Working register: loaded with a on acceptance; for SHL it is reloaded with alu_y every EXEC cycle.
  - Each EXEC cycle registers alu_y, alu_cout and alu_zero into rsp_y, rsp_cout and rsp_zero.
  - ADD/SUB/AND/OR: exactly 1 EXEC cycle.
  - SHL: shamt EXEC cycles; count is loaded with shamt and decremented per cycle; exit to RESP when count==1.
- Outside EXEC: alu_op=3'b111 (ALU default, Y=0); alu_a=0; alu_b=0.
- Latency from the acceptance edge to rsp_valid=1:
  - ADD/SUB/AND/OR: 2 cycles.
  - SHL N (N>=1): N+1 cycles.
  - Illegal op or shamt=0: 1 cycle.
- RESP state:
  - rsp_valid=1; rsp_* held stable until rsp_valid&rsp_ready.
  - On that handshake: return to IDLE, drop rsp_valid, and raise cmd_ready in the same edge.
  - A new command is never accepted in the cycle the response is consumed; minimum back-to-back spacing is 3 cycles.
- Arithmetic: all arithmetic is done by the external ALU; no internal adders except the SHAMT_W-bit count decrement. SUB carry follows the ALU's no-borrow convention.
- Backpressure: rsp_ready may stay low indefinitely; the block stalls in RESP and cmd_ready stays 0.
- Reset mid-operation: reset in any state aborts the in-flight command. Next cycle: IDLE with reset values; no response is produced for the aborted command.
- cmd_* changing while cmd_ready=0 has no effect.

Optional Feature:
- Macro: ALU_SEQ_PERF_EN.
- Defined: adds outputs perf_cmds (32, count of completed response handshakes) and perf_busy (32, cycles not in IDLE). Both reset to 0, wrap at 2^32, are not cleared otherwise, and do not affect functional timing.
- Undefined: ports and counters are absent; the block is otherwise identical.

Decomposition:
- Shared package alu_seq_pkg:
  - opcode constants OP_ADD=3'b000, OP_SUB=3'b001, OP_AND=3'b010, OP_OR=3'b011, OP_SHL=3'b100, OP_NOP=3'b111;
  - FSM state encoding (IDLE, EXEC, RESP);
  - helper function is_legal_op.
- The ALU is not instantiated inside; the parent wires alu_* to the ALU.
- Sub-module: none required; the FSM and datapath are a single module. If ALU_SEQ_PERF_EN grows, the counters may move to alu_seq_perf.

Test Plan:
- ADD a=0xFFFFFFFF, b=0x00000001 -> rsp_valid 2 cycles after accept; y=0x00000000, cout=1, zero=1, err=0.
- SUB a=5, b=7 -> y=0xFFFFFFFE, cout=0, zero=0; SUB a=7, b=5 -> y=2, cout=1.
- SHL a=0x00000003, shamt=4 -> exactly 4 EXEC cycles with alu_op=100; rsp_valid 5 cycles after accept; y=0x00000030. SHL a=0x80000000, shamt=1 -> y=0, zero=1.
- Illegal op 110 and SHL shamt=0 (a=0x1234) -> rsp_valid 1 cycle after accept. Op 110 gives err=1, y=0; shamt=0 gives y=0x1234, err=0. alu_op stays 111 throughout both.
- Backpressure and spacing: AND a=0xF0F0F0F0, b=0xFF00FF00 with rsp_ready low for 10 cycles -> y=0xF000F000 held stable, cmd_ready=0 throughout; release -> cmd_ready=1 the next cycle.
- Reset asserted during SHL shamt=20 at its 7th EXEC cycle -> next cycle IDLE, cmd_ready=1, rsp_valid=0, and no response ever appears; a subsequent OR 0x1|0x2 returns y=3.
